// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one 8-bit ALU; round-robin grant, one op in flight.
// Latency: response valid two cycles after the request handshake. Backpressure: the owner holds
// the result with rsp_ready low; both req_ready stay low until the response is consumed.

module alu (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] s_i,
    output logic [7:0] result_o,
    output logic [3:0] flags_o
);

    logic [8:0] sum;
    logic       carry;
    logic       ovf;

    always_comb begin
        sum      = 9'd0;
        carry    = 1'b0;
        ovf      = 1'b0;
        result_o = 8'd0;
        case (s_i)
            3'b000: begin
                sum      = {1'b0, a_i} + {1'b0, b_i};
                result_o = sum[7:0];
                carry    = sum[8];
                ovf      = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            3'b001: begin
                // Carry out of a + ~b + 1 is the inverted borrow.
                sum      = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
                result_o = sum[7:0];
                carry    = sum[8];
                ovf      = (a_i[7] != b_i[7]) && (sum[7] != a_i[7]);
            end
            3'b010:  result_o = a_i & b_i;
            3'b011:  result_o = a_i | b_i;
            3'b100:  result_o = ~a_i;
            3'b101:  result_o = a_i ^ b_i;
            3'b110:  result_o = {a_i[6:0], 1'b0};
            default: result_o = {1'b0, a_i[7:1]};
        endcase
    end

    assign flags_o = {(result_o == 8'd0), result_o[7], carry, ovf};

endmodule

module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_s,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_s,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_result,
    output logic [3:0] rsp0_flags,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_result,
    output logic [3:0] rsp1_flags,
    input  logic       rsp1_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       owner_q, owner_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] s_q, s_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;

    logic       any_vld;
    logic       grant;
    logic       hs;
    logic       owner_rsp_rdy;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .s_i      (s_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // A tie goes to whichever requester was not served last.
    always_comb begin
        any_vld = req0_valid | req1_valid;
        grant   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        hs            = (state_q == ST_IDLE) && any_vld && !rst;
        owner_rsp_rdy = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_vld) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (owner_rsp_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        s_d          = s_q;
        result_d     = result_q;
        flags_d      = flags_q;
        if (hs) begin
            last_grant_d = grant;
            owner_d      = grant;
            a_d          = grant ? req1_a : req0_a;
            b_d          = grant ? req1_b : req0_b;
            s_d          = grant ? req1_s : req0_s;
        end
        if (state_q == ST_EXEC) begin
            result_d = alu_result;
            flags_d  = alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            s_q          <= 3'd0;
            result_q     <= 8'd0;
            flags_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    // Outputs are forced low while rst is high so nothing leaks from a stale state.
    always_comb begin
        req0_ready  = hs && !grant;
        req1_ready  = hs && grant;
        rsp0_valid  = !rst && (state_q == ST_RESP) && !owner_q;
        rsp1_valid  = !rst && (state_q == ST_RESP) && owner_q;
        rsp0_result = rsp0_valid ? result_q : 8'd0;
        rsp0_flags  = rsp0_valid ? flags_q : 4'd0;
        rsp1_result = rsp1_valid ? result_q : 8'd0;
        rsp1_flags  = rsp1_valid ? flags_q : 4'd0;
        busy        = !rst && (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed stimulus for alu_arbiter against a transaction-level reference model.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.

module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_s, req1_s;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_result, rsp1_result;
    logic [3:0] rsp0_flags, rsp1_flags;
    logic       rsp0_ready, rsp1_ready;
    logic       busy;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_s      (req0_s),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_s      (req1_s),
        .req1_ready  (req1_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_result (rsp0_result),
        .rsp0_flags  (rsp0_flags),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_result (rsp1_result),
        .rsp1_flags  (rsp1_flags),
        .rsp1_ready  (rsp1_ready),
        .busy        (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference ALU in plain integer arithmetic; returns {result, z, n, c, v}.
    function automatic logic [11:0] ref_alu(input int a, input int b, input int s);
        int r, sa, sb, sr;
        logic c, v;
        logic [7:0] rr;
        c  = 1'b0;
        v  = 1'b0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (s)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            1: begin r = a - b; c = (a >= b); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = 255 - a;
            5: r = a ^ b;
            6: r = a * 2;
            default: r = a / 2;
        endcase
        r  = ((r % 256) + 256) % 256;
        rr = r[7:0];
        return {rr, (r == 0), (r >= 128), c, v};
    endfunction

    // Model: at most one operation outstanding, answered two cycles after its handshake.
    bit          m_inflight = 1'b0;
    bit          m_own      = 1'b0;
    bit          m_last     = 1'b1;
    logic [11:0] m_exp      = 12'd0;
    int          m_hs       = 0;
    int          cyc        = 0;
    int          q_own[$];
    int          q_cyc[$];

    task automatic step(input bit r, input bit v0, input bit v1,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] s0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] s1,
                        input bit y0, input bit y1);
        bit g, e_r0, e_r1, e_b, e_v0, e_v1;
        logic [7:0] e_res0, e_res1;
        logic [3:0] e_f0, e_f1;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_s = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_s = s1;
        rsp0_ready = y0; rsp1_ready = y1;
        #1;
        {e_r0, e_r1, e_b, e_v0, e_v1} = '0;
        e_res0 = 8'd0; e_res1 = 8'd0; e_f0 = 4'd0; e_f1 = 4'd0;
        g = (v0 && v1) ? ~m_last : v1;
        if (!r) begin
            if (!m_inflight) begin
                e_r0 = (v0 || v1) && !g;
                e_r1 = (v0 || v1) && g;
            end else begin
                e_b = 1'b1;
                if (cyc >= m_hs + 2) begin
                    if (m_own) begin e_v1 = 1'b1; e_res1 = m_exp[11:4]; e_f1 = m_exp[3:0]; end
                    else       begin e_v0 = 1'b1; e_res0 = m_exp[11:4]; e_f0 = m_exp[3:0]; end
                end
            end
        end
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("busy", busy, e_b);
        chk("rsp0_valid", rsp0_valid, e_v0);
        chk("rsp1_valid", rsp1_valid, e_v1);
        chk("rsp0_result", rsp0_result, e_res0);
        chk("rsp1_result", rsp1_result, e_res1);
        chk("rsp0_flags", rsp0_flags, e_f0);
        chk("rsp1_flags", rsp1_flags, e_f1);
        if (req0_valid && req0_ready) begin q_own.push_back(0); q_cyc.push_back(cyc); end
        if (req1_valid && req1_ready) begin q_own.push_back(1); q_cyc.push_back(cyc); end
        if (r) begin
            m_inflight = 1'b0;
            m_last     = 1'b1;
        end else if (!m_inflight && (v0 || v1)) begin
            m_inflight = 1'b1;
            m_own      = g;
            m_last     = g;
            m_hs       = cyc;
            m_exp      = g ? ref_alu(int'(a1), int'(b1), int'(s1)) : ref_alu(int'(a0), int'(b0), int'(s0));
        end else if (m_inflight && (cyc >= m_hs + 2) && (m_own ? y1 : y0)) begin
            m_inflight = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesters active: every output must stay low.
        step(1, 1, 1, 8'h11, 8'h22, 3'd0, 8'h33, 8'h44, 3'd1, 1, 1);
        step(1, 1, 1, 8'h11, 8'h22, 3'd0, 8'h33, 8'h44, 3'd1, 1, 1);
        chk("rst_busy", busy, 0);

        // ADD overflow on requester 0.
        step(0, 1, 0, 8'h7F, 8'h01, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        chk("add_vld", rsp0_valid, 1);
        chk("add_res", rsp0_result, 8'h80);
        chk("add_flg", rsp0_flags, 4'b0101);

        // SUB to zero on requester 1; requester 0 sees nothing.
        step(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h05, 8'h05, 3'd1, 1, 1);
        step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        chk("sub_res", rsp1_result, 8'h00);
        chk("sub_flg", rsp1_flags, 4'b1010);
        chk("sub_rsp0", rsp0_valid, 0);
        idle(1);

        // Continuous contention right after reset: strict alternation, 3 cycles apart.
        step(1, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        q_own.delete();
        q_cyc.delete();
        for (int i = 0; i < 12; i++)
            step(0, 1, 1, 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1, 1);
        chk("rr_count", q_own.size(), 4);
        if (q_own.size() >= 4) begin
            chk("rr_g0", q_own[0], 0);
            chk("rr_g1", q_own[1], 1);
            chk("rr_g2", q_own[2], 0);
            chk("rr_g3", q_own[3], 1);
            for (int i = 0; i < 3; i++) chk("rr_gap", q_cyc[i+1] - q_cyc[i], 3);
        end
        idle(3);

        // Backpressure: owner holds off for 5 RESP cycles while the other side pokes at inputs.
        step(0, 1, 0, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 3'd0, 0, 0);
        step(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h99, 8'h01, 3'd5, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 8'hAA, 8'h55, 3'd1, 8'h99, 8'h01, 3'd5, 0, 1);
        chk("bp_res", rsp0_result, 8'h46);
        chk("bp_busy", busy, 1);
        step(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h99, 8'h01, 3'd5, 1, 0);
        step(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h99, 8'h01, 3'd5, 1, 1);
        chk("bp_idle", busy, 0);
        chk("wait_rdy1", req1_ready, 1);
        step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        idle(2);

        // Reset during EXEC drops the operation; the next tie goes to requester 0.
        step(0, 1, 0, 8'hF0, 8'h3C, 3'd2, 8'h00, 8'h00, 3'd0, 1, 1);
        step(1, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        step(0, 0, 0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        chk("rstx_v0", rsp0_valid, 0);
        chk("rstx_busy", busy, 0);
        step(0, 1, 1, 8'h01, 8'h02, 3'd0, 8'h03, 8'h04, 3'd0, 1, 1);
        chk("rstx_tie", req0_ready, 1);
        idle(3);

        // Operand changes after the handshake do not reach the result.
        step(0, 1, 0, 8'h10, 8'h20, 3'd0, 8'h00, 8'h00, 3'd0, 1, 1);
        step(0, 1, 0, 8'hFF, 8'hFF, 3'd7, 8'h00, 8'h00, 3'd0, 1, 1);
        step(0, 1, 0, 8'hFF, 8'hFF, 3'd7, 8'h00, 8'h00, 3'd0, 1, 1);
        chk("latch_res", rsp0_result, 8'h30);
        idle(2);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 8'($urandom), 8'($urandom), 3'($urandom),
                 8'($urandom), 8'($urandom), 3'($urandom),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Timing SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: synchronous active-high reset.
REQ-004 Ports req0_valid / req1_valid, input, 1 each: requester i presents an operation.
REQ-005 Ports req0_a, req0_b / req1_a, req1_b, input, 8 each: operands for requester i.
REQ-006 Ports req0_s / req1_s, input, 3 each: ALU op select, same encoding as the team ALU (000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 XOR, 110 SHL1, 111 SHR1).
REQ-007 Ports req0_ready / req1_ready, output, 1 each: operation accepted on cycles where valid and ready are both 1.
REQ-008 Ports rsp0_valid / rsp1_valid, output, 1 each: response for requester i is available.
REQ-009 Ports rsp0_result / rsp1_result, output, 8 each: ALU result for requester i.
REQ-010 Ports rsp0_flags / rsp1_flags, output, 4 each: {z, n, c, v}, same as the ALU flags_out.
REQ-011 Ports rsp0_ready / rsp1_ready, input, 1 each: requester i consumes the response.
REQ-012 Port busy, output, 1: state is not IDLE.

Function
REQ-013 The block SHALL instantiate exactly one team ALU (module alu) and share it between the two requesters.
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-015 IDLE: the grant SHALL be computed combinationally from the valids and the last_grant register.
REQ-016 In IDLE with exactly one valid, that requester SHALL be granted.
REQ-017 In IDLE with both valid, the requester not equal to last_grant SHALL be granted (round-robin).
REQ-018 req_i_ready SHALL be 1 only in IDLE when requester i is granted; it SHALL be 0 in EXEC and RESP.
REQ-019 On handshake, the block SHALL latch a, b, s and the owner ID, set last_grant to the owner, and go to EXEC.
REQ-020 EXEC (one cycle): the ALU SHALL be driven from the latched operands, its result and flags SHALL be registered, and the FSM SHALL go to RESP.
REQ-021 RESP: rsp_valid SHALL be 1 for the owner only, and 0 for the other requester.
REQ-022 In RESP, the owner's rsp_result and rsp_flags SHALL be held stable until the owner's rsp_ready is 1.
REQ-023 In RESP, when the owner's rsp_ready is 1, the FSM SHALL go to IDLE on the next edge.
REQ-024 Latency: for a handshake in cycle T, rsp_valid SHALL be 1 from cycle T+2; maximum throughput is one operation per 3 cycles.
REQ-025 Requester valids, operands and the non-owner rsp_ready SHALL be ignored outside IDLE; later changes SHALL NOT alter the latched operation.
REQ-026 rsp_result and rsp_flags SHALL be 0 whenever the corresponding rsp_valid is 0.
REQ-027 Arithmetic SHALL be exactly as the ALU: 8-bit wrap; c = carry-out for ADD and inverted borrow for SUB, 0 otherwise; v = signed overflow for ADD/SUB only.
REQ-028 Simultaneous events: a new valid arriving during RESP SHALL wait; it SHALL be arbitrated in the first IDLE cycle after release.

Reset
REQ-029 While rst is 1 at an edge: state SHALL become IDLE, last_grant SHALL become 1 (requester 0 wins the first tie), and the latched operands, result and flags SHALL clear to 0.
REQ-030 All outputs SHALL be 0 during and immediately after reset, except that req_ready follows REQ-018 once rst is 0.
REQ-031 Reset in EXEC or RESP SHALL drop the in-flight operation: no response is delivered and there is no retry.

Verification
REQ-032 req0 ADD a=0x7F, b=0x01 -> rsp0_valid at T+2, result 0x80, flags 4'b0101.
REQ-033 req1 SUB a=0x05, b=0x05 -> rsp1 result 0x00, flags 4'b1010; rsp0_valid stays 0 throughout.
REQ-034 After reset, both valid continuously with rsp_ready=1 -> grant order req0, req1, req0, req1; each handshake exactly 3 cycles apart.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> result and flags unchanged, busy=1, both req_ready=0; release -> IDLE on the next edge.
REQ-036 Assert rst during EXEC of req0 AND 0xF0,0x3C -> next cycle IDLE, all rsp_valid=0, no response; a fresh tie is granted to req0.
REQ-037 Change req0_a after handshake, during EXEC -> the response reflects the originally latched operands.
